clk_div_monitor: RTL
====================

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 Parameter DIV, default 5, expected clk_div period in clk cycles (range 2..TIMEOUT-1).
REQ-002 Parameter CNT_W, default 8, width of all period/high-time counters.
REQ-003 Parameter LOCK_N, default 4, consecutive matching periods required to assert locked.
REQ-004 Parameter TIMEOUT, default 255, cycles without a clk_div rising edge before timeout (≤ 2^CNT_W-1).
REQ-005 clk  input  1  monitor clock, rising edge only.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 clk_div  input  1  divided clock under test, treated as asynchronous data.
REQ-008 err_clr  input  1  one-cycle pulse clearing err and timeout.
REQ-009 period  output  CNT_W  last measured rise-to-rise period, in clk cycles.
REQ-010 hi_time  output  CNT_W  clk samples with clk_div high in the last measured period.
REQ-011 period_vld  output  1  one-cycle pulse; period and hi_time updated.
REQ-012 locked  output  1  clk_div period equals DIV for LOCK_N consecutive periods.
REQ-013 err  output  1  sticky; a period ≠ DIV was seen while locked.
REQ-014 timeout  output  1  sticky; no clk_div rising edge for TIMEOUT cycles.

Function
REQ-015 The block SHALL pass clk_div through a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 & ~s3.
REQ-016 The counter cnt SHALL load 1 on a rise cycle; otherwise it increments by 1, saturating at 2^CNT_W-1.
REQ-017 The counter hcnt SHALL load 1 on a rise cycle; otherwise it adds s2, saturating.
REQ-018 FSM states: IDLE, MEASURE, LOCK; reset state IDLE.
REQ-019 IDLE: on rise, go to MEASURE with no period_vld; cnt and hcnt are not meaningful in IDLE.
REQ-020 MEASURE/LOCK: on rise, the block SHALL register period<=cnt and hi_time<=hcnt, and SHALL pulse period_vld on the following cycle (latency 1).
REQ-021 Match = (cnt == DIV) at a rise. match_cnt increments on a match, saturating at LOCK_N, and clears to 0 on a mismatch.
REQ-022 MEASURE→LOCK on the rise that brings match_cnt to LOCK_N; locked=1 exactly while in LOCK, registered, asserted the same cycle period_vld pulses.
REQ-023 LOCK + mismatch: go to MEASURE, clear match_cnt, set err.
REQ-024 MEASURE + mismatch: clear match_cnt only; err is not set.
REQ-025 In MEASURE/LOCK, if cnt == TIMEOUT and there is no rise: set timeout, go to IDLE, clear match_cnt, no period_vld.
REQ-026 In IDLE, timeout SHALL never be raised.
REQ-027 err_clr clears err and timeout; a set condition in the same cycle wins (flag stays 1).
REQ-028 period and hi_time SHALL hold their values between period_vld pulses, including across timeout.

Reset
REQ-029 On rst the block SHALL set: state=IDLE, s1/s2/s3=0, cnt=0, hcnt=0, match_cnt=0, period=0, hi_time=0, period_vld=0, locked=0, err=0, timeout=0.
REQ-030 rst asserted mid-measurement SHALL discard the partial period; the first rise after release only enters MEASURE.

Verification
REQ-031 Bench stream, defaults, clk_div high 2 / low 3 repeating → first rise gives no pulse; every later rise gives period=5, hi_time=2, period_vld one cycle; locked=1 on the 4th pulse.
REQ-032 While locked, stretch one low phase to 4 (period 6) → pulse with period=6, locked=0, err=1; the next 4 periods of 5 re-lock and err stays 1.
REQ-033 While locked, hold clk_div low → timeout=1 and locked=0 exactly 255 cycles after the last rise; the next rise gives no pulse and the following rise gives period=5.
REQ-034 Assert err_clr in the same cycle a locked mismatch sets err → err stays 1; err_clr alone one cycle later → err=0, timeout=0.
REQ-035 rst for 1 cycle while locked → all outputs 0 next cycle; re-lock requires 1+LOCK_N rises.
REQ-036 Drive clk_div from a ÷5 50%-duty divider on the same clk → period=5 every pulse, hi_time ∈ {2,3}, locked=1, err=0.

Source files
------------

// File: rtl/clk_div_monitor.sv
// Clock divider monitor: measures the rise-to-rise period and high time of an
// asynchronous clk_div, tracks lock against DIV, and flags errors and timeouts.
module clk_div_monitor #(
  parameter int DIV     = 5,
  parameter int CNT_W   = 8,
  parameter int LOCK_N  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] hi_time,
  output logic             period_vld,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LOCK_C  = MW'(LOCK_N);
  localparam logic [MW-1:0]    MC_ONE  = MW'(1);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCK} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d, hi_time_q, hi_time_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic             period_vld_q, period_vld_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d, timeout_q, timeout_d;
  logic             rise, match, err_set, to_set;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic inc);
    if (inc && (a != CNT_MAX)) return a + CNT_ONE;
    return a;
  endfunction

  always_comb begin
    s1_d         = clk_div;
    s2_d         = s1_q;
    s3_d         = s2_q;
    rise         = s2_q & ~s3_q;
    match        = (cnt_q == DIV_C);
    cnt_d        = rise ? CNT_ONE : sat_add(cnt_q, 1'b1);
    hcnt_d       = rise ? CNT_ONE : sat_add(hcnt_q, s2_q);
    state_d      = state_q;
    period_d     = period_q;
    hi_time_d    = hi_time_q;
    match_cnt_d  = match_cnt_q;
    period_vld_d = 1'b0;
    err_set      = 1'b0;
    to_set       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Counters are stale here, so the first rise only arms measurement.
        if (rise) state_d = S_MEASURE;
      end
      S_MEASURE, S_LOCK: begin
        if (rise) begin
          period_d     = cnt_q;
          hi_time_d    = hcnt_q;
          period_vld_d = 1'b1;
          if (match) begin
            match_cnt_d = (match_cnt_q == LOCK_C) ? LOCK_C : match_cnt_q + MC_ONE;
            if (match_cnt_d == LOCK_C) state_d = S_LOCK;
          end else begin
            match_cnt_d = '0;
            if (state_q == S_LOCK) begin
              err_set = 1'b1;
              state_d = S_MEASURE;
            end
          end
        end else if (cnt_q == TO_C) begin
          to_set      = 1'b1;
          match_cnt_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    locked_d  = (state_d == S_LOCK);
    // A new error or timeout takes priority over a simultaneous clear.
    err_d     = err_set | (err_q & ~err_clr);
    timeout_d = to_set | (timeout_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      match_cnt_q  <= '0;
      period_q     <= '0;
      hi_time_q    <= '0;
      period_vld_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      match_cnt_q  <= match_cnt_d;
      period_q     <= period_d;
      hi_time_q    <= hi_time_d;
      period_vld_q <= period_vld_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period     = period_q;
  assign hi_time    = hi_time_q;
  assign period_vld = period_vld_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign timeout    = timeout_q;

endmodule
